// File: rtl/epp_ctrl.sv
// ---------------------------------------------------------------------------
// epp_ctrl - EPP (Enhanced Parallel Port) slave controller, host side.
//
// Decodes the host's address and data strobes on an 8-bit bidirectional bus.
// Keeps an address register and turns each host data cycle into a simple
// internal register-bus access.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   EppAstb, EppDstb  host address / data strobes (active-low, asynchronous)
//   EppWr             host direction: 0 = host write, 1 = host read
//   DB                bidirectional data bus; driven only during read cycles
//   EppWait           handshake to host: 1 = cycle accepted / read data valid
//   cs                internal chip select, high for the whole data cycle
//   stbData           one-clock internal data strobe
//   ctrlWr            internal direction, 1 = write to user logic
//   busIn             read data from user logic
//   busOut            registered write data to user logic
//   outEppAdr         current address (adr[6:0])
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module epp_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EppAstb,
    input  logic       EppDstb,
    input  logic       EppWr,
    inout  wire  [7:0] DB,
    output logic       EppWait,
    output logic       cs,
    output logic       stbData,
    output logic       ctrlWr,
    input  logic [7:0] busIn,
    output logic [7:0] busOut,
    output logic [6:0] outEppAdr
);

    typedef enum logic [2:0] {IDLE, A_WR, A_RD, D_WR, D_RD, HOLD} stateT;

    stateT state, stateNext;

    logic [SYNC_STAGES-1:0] astbSync, dstbSync, wrSync;
    logic       astbS, dstbS, wrS;
    logic [7:0] adr;
    logic [7:0] rdData;
    logic       cycAdr;     // current cycle is an address cycle
    logic       cycRd;      // current cycle is a host read
    logic       dbOe;
    logic [7:0] dbOut;

    // Strobe/direction synchronizers; idle level of all three lines is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            astbSync <= '1;
            dstbSync <= '1;
            wrSync   <= '1;
        end else begin
            astbSync <= {astbSync[SYNC_STAGES-2:0], EppAstb};
            dstbSync <= {dstbSync[SYNC_STAGES-2:0], EppDstb};
            wrSync   <= {wrSync[SYNC_STAGES-2:0], EppWr};
        end
    end

    assign astbS = astbSync[SYNC_STAGES-1];
    assign dstbS = dstbSync[SYNC_STAGES-1];
    assign wrS   = wrSync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Address strobe wins when both are low, so a simultaneous assertion
    // runs only the address cycle; HOLD then waits for both to rise.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!astbS)      stateNext = wrS ? A_RD : A_WR;
                else if (!dstbS) stateNext = wrS ? D_RD : D_WR;
            end
            A_WR, A_RD, D_WR, D_RD: stateNext = HOLD;
            HOLD: if (astbS && dstbS) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // All handshake/strobe outputs are registered from the next state so
    // they line up with the state they belong to and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EppWait <= 1'b0;
            stbData <= 1'b0;
            cs      <= 1'b0;
            ctrlWr  <= 1'b0;
            busOut  <= '0;
            rdData  <= '0;
            adr     <= '0;
            cycAdr  <= 1'b0;
            cycRd   <= 1'b0;
        end else begin
            EppWait <= (stateNext == HOLD);
            stbData <= (stateNext == D_WR) || (stateNext == D_RD);
            cs      <= (stateNext == D_WR) || (stateNext == D_RD) ||
                       ((stateNext == HOLD) && cs);
            ctrlWr  <= (stateNext == D_WR) || ((stateNext == HOLD) && ctrlWr);
            if (stateNext == D_WR) busOut <= DB;
            if (stateNext == D_RD) rdData <= busIn;
            if (state == A_WR)     adr    <= DB;
            // Cycle type is frozen on leaving IDLE; EppWr changes in HOLD
            // have no effect.
            if (state == IDLE && stateNext != IDLE) begin
                cycAdr <= !astbS;
                cycRd  <= wrS;
            end
        end
    end

    // Read data goes onto DB in the action state, one clock before EppWait.
    assign dbOe      = (state == A_RD) || (state == D_RD) || ((state == HOLD) && cycRd);
    assign dbOut     = cycAdr ? adr : rdData;
    assign DB        = dbOe ? dbOut : 8'bzzzz_zzzz;
    assign outEppAdr = adr[6:0];

endmodule

// File: tb/tb_epp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_epp_ctrl - self-checking bench for epp_ctrl.
// Steady-state behaviour is checked from a vector table; the one-clock
// strobe, latencies, simultaneous strobes and mid-cycle reset are checked
// with hand-written sequences. DB carries pull-ups, so a released bus
// reads as 8'hFF.
// ---------------------------------------------------------------------------
module tb_epp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       EppAstb, EppDstb, EppWr;
    tri1  [7:0] DB;
    logic       EppWait, cs, stbData, ctrlWr;
    logic [7:0] busIn, busOut;
    logic [6:0] outEppAdr;

    logic       tbDrv;
    logic [7:0] tbDb;

    int nChecks = 0;
    int nErrors = 0;

    assign DB = tbDrv ? tbDb : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    epp_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .EppAstb(EppAstb), .EppDstb(EppDstb), .EppWr(EppWr),
        .DB(DB), .EppWait(EppWait), .cs(cs), .stbData(stbData),
        .ctrlWr(ctrlWr), .busIn(busIn), .busOut(busOut), .outEppAdr(outEppAdr)
    );

    typedef struct {
        logic       astb, dstb, wr, drv;
        logic [7:0] db, bin;
        logic       wt, cs, cw, stb;
        logic [6:0] adr;
        logic [7:0] bout, dbx;
    } vecT;

    vecT vec[14];

    function automatic vecT mk(logic astb, logic dstb, logic wr, logic drv,
                               logic [7:0] db, logic [7:0] bin,
                               logic wt, logic c, logic cw, logic stb,
                               logic [6:0] adr, logic [7:0] bout, logic [7:0] dbx);
        vecT v;
        v.astb = astb; v.dstb = dstb; v.wr = wr; v.drv = drv;
        v.db = db; v.bin = bin;
        v.wt = wt; v.cs = c; v.cw = cw; v.stb = stb;
        v.adr = adr; v.bout = bout; v.dbx = dbx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkOuts(input string nm, input vecT v);
        chk({nm, ".EppWait"}, {7'd0, EppWait}, {7'd0, v.wt});
        chk({nm, ".cs"}, {7'd0, cs}, {7'd0, v.cs});
        chk({nm, ".ctrlWr"}, {7'd0, ctrlWr}, {7'd0, v.cw});
        chk({nm, ".stbData"}, {7'd0, stbData}, {7'd0, v.stb});
        chk({nm, ".outEppAdr"}, {1'b0, outEppAdr}, {1'b0, v.adr});
        chk({nm, ".busOut"}, busOut, v.bout);
        chk({nm, ".DB"}, DB, v.dbx);
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int stbCnt, lat;
        logic [7:0] prevDb;
        logic seenWait;

        //            astb dstb wr drv db     bin    | wt cs cw stb adr    bout   dbx
        vec[0]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h00, 8'h00, 8'hFF);
        vec[1]  = mk(0, 1, 0, 1, 8'h85, 8'h00, 1, 0, 0, 0, 7'h05, 8'h00, 8'h85);
        vec[2]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h05, 8'h00, 8'hFF);
        vec[3]  = mk(0, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 7'h05, 8'h00, 8'h85);
        vec[4]  = mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h05, 8'h00, 8'hFF);
        vec[5]  = mk(1, 0, 0, 1, 8'h3C, 8'h00, 1, 1, 1, 0, 7'h05, 8'h3C, 8'h3C);
        vec[6]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h05, 8'h3C, 8'hFF);
        vec[7]  = mk(1, 0, 1, 0, 8'h00, 8'hA7, 1, 1, 0, 0, 7'h05, 8'h3C, 8'hA7);
        vec[8]  = mk(1, 0, 0, 0, 8'h00, 8'hA7, 1, 1, 0, 0, 7'h05, 8'h3C, 8'hA7);
        vec[9]  = mk(1, 1, 0, 0, 8'h00, 8'hA7, 0, 0, 0, 0, 7'h05, 8'h3C, 8'hFF);
        vec[10] = mk(0, 1, 0, 1, 8'hFE, 8'h00, 1, 0, 0, 0, 7'h7E, 8'h3C, 8'hFE);
        vec[11] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h7E, 8'h3C, 8'hFF);
        vec[12] = mk(0, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 7'h7E, 8'h3C, 8'hFE);
        vec[13] = mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 7'h7E, 8'h3C, 8'hFF);

        // Reset with strobes idle
        rst_n = 1'b0; EppAstb = 1'b1; EppDstb = 1'b1; EppWr = 1'b0;
        tbDrv = 1'b0; tbDb = 8'h00; busIn = 8'h00;
        clocks(3);
        chkOuts("reset", vec[0]);
        rst_n = 1'b1;

        // Table: hold each vector long enough to reach steady state
        for (int i = 0; i < 14; i++) begin
            EppAstb = vec[i].astb; EppDstb = vec[i].dstb; EppWr = vec[i].wr;
            tbDrv = vec[i].drv; tbDb = vec[i].db; busIn = vec[i].bin;
            clocks(8);
            chkOuts($sformatf("vec%0d", i), vec[i]);
        end

        // Data write: single strobe, latencies
        tbDrv = 1'b1; tbDb = 8'h5A; EppWr = 1'b0; EppDstb = 1'b0;
        stbCnt = 0; lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (stbData) begin
                stbCnt++;
                chk("wrPulse.cs", {7'd0, cs}, 8'd1);
                chk("wrPulse.ctrlWr", {7'd0, ctrlWr}, 8'd1);
                chk("wrPulse.busOut", busOut, 8'h5A);
                chk("wrPulse.EppWait", {7'd0, EppWait}, 8'd0);
            end
            if (EppWait && lat == 0) lat = n;
        end
        chk("wr.stbCount", stbCnt[7:0], 8'd1);
        chk("wr.waitLatencyOk", {7'd0, (lat >= 1 && lat <= 4)}, 8'd1);
        EppDstb = 1'b1; tbDrv = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (!EppWait) begin lat = n; break; end
        end
        chk("wr.releaseLatencyOk", {7'd0, (lat >= 1 && lat <= 4)}, 8'd1);
        clocks(2);

        // Data read: DB valid before EppWait rises
        busIn = 8'hC3; EppWr = 1'b1; EppDstb = 1'b0;
        stbCnt = 0; prevDb = 8'hFF; seenWait = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (stbData) begin
                stbCnt++;
                chk("rdPulse.cs", {7'd0, cs}, 8'd1);
                chk("rdPulse.ctrlWr", {7'd0, ctrlWr}, 8'd0);
            end
            if (EppWait && !seenWait) begin
                seenWait = 1'b1;
                chk("rd.dbBeforeWait", prevDb, 8'hC3);
            end
            prevDb = DB;
        end
        chk("rd.stbCount", stbCnt[7:0], 8'd1);
        chk("rd.waitSeen", {7'd0, seenWait}, 8'd1);
        EppDstb = 1'b1;
        clocks(8);
        chk("rd.released", DB, 8'hFF);

        // Both strobes low: address cycle only, then reset in HOLD
        EppWr = 1'b0; tbDrv = 1'b1; tbDb = 8'h12;
        EppAstb = 1'b0; EppDstb = 1'b0;
        stbCnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (stbData) stbCnt++;
        end
        chk("both.stbCount", stbCnt[7:0], 8'd0);
        chk("both.outEppAdr", {1'b0, outEppAdr}, 8'h12);
        chk("both.busOut", busOut, 8'h5A);
        chk("both.EppWait", {7'd0, EppWait}, 8'd1);
        tbDrv = 1'b0;
        clocks(2);
        #2 rst_n = 1'b0;
        #1;
        chk("midRst.EppWait", {7'd0, EppWait}, 8'd0);
        chk("midRst.outEppAdr", {1'b0, outEppAdr}, 8'h00);
        chk("midRst.DB", DB, 8'hFF);
        EppAstb = 1'b1; EppDstb = 1'b1;
        clocks(3);
        rst_n = 1'b1;

        // Reset during an address-read HOLD releases DB at once
        EppWr = 1'b1; EppAstb = 1'b0;
        clocks(8);
        chk("rdRst.before.DB", DB, 8'h00);
        chk("rdRst.before.EppWait", {7'd0, EppWait}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rdRst.DB", DB, 8'hFF);
        chk("rdRst.EppWait", {7'd0, EppWait}, 8'd0);
        EppAstb = 1'b1;
        clocks(3);
        rst_n = 1'b1;
        clocks(2);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
